bitslip_align: RTL and testbench

//  Multi-lane word aligner for deserialised (ISERDES-style) parallel data. Each lane has a
//  1-cycle bitslip barrel shifter plus a training FSM that slips until TRAIN_PATTERN is seen

---
 rtl/bitslip_pkg.sv | 25 ++
 rtl/bitslip_lane.sv | 130 +++++++++++++
 rtl/bitslip_align.sv | 57 +++++
 tb/tb_bitslip_align.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bitslip_pkg.sv
// Shared types and helpers for the multi-lane bitslip word aligner.
package bitslip_pkg;

    // Ceiling log2, never below 1 so a count of 1 or 2 still gets a usable width.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned res;
        res = 1;
        for (int i = 1; i < 32; i++) begin
            if (value > (32'd1 << i)) res = 32'(i + 1);
        end
        return res;
    endfunction

    localparam logic [7:0] DEFAULT_TRAIN_PATTERN = 8'h5C;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_SLIP   = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } lane_state_e;

endpackage

// File: rtl/bitslip_lane.sv
// One lane: 1-cycle bitslip barrel shifter and the training FSM that hunts for the pattern.
module bitslip_lane
    import bitslip_pkg::*;
#(
    parameter int unsigned          DATA_BITS     = 8,
    parameter int unsigned          CNT_BITS      = clogb2(DATA_BITS),
    parameter logic [DATA_BITS-1:0] TRAIN_PATTERN = DATA_BITS'(DEFAULT_TRAIN_PATTERN),
    parameter int unsigned          SETTLE_CYCLES = 3,
    parameter int unsigned          MATCH_COUNT   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 align_en,
    input  logic                 restart,
    input  logic                 manual_en,
    input  logic [CNT_BITS-1:0]  manual_bitpos,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout,
    output logic [CNT_BITS-1:0]  bitpos,
    output logic                 lane_locked,
    output logic                 lane_err
);

    localparam int unsigned WAIT_BITS  = clogb2(SETTLE_CYCLES);
    localparam int unsigned MATCH_BITS = clogb2(MATCH_COUNT);

    localparam logic [CNT_BITS-1:0]   POS_LAST   = CNT_BITS'(DATA_BITS - 1);
    localparam logic [WAIT_BITS-1:0]  WAIT_LAST  = WAIT_BITS'(SETTLE_CYCLES - 1);
    localparam logic [MATCH_BITS-1:0] MATCH_LAST = MATCH_BITS'(MATCH_COUNT - 1);

    lane_state_e            state;
    logic [DATA_BITS-1:0]   din_1;
    logic [WAIT_BITS-1:0]   wait_cnt;
    logic [CNT_BITS-1:0]    slip_cnt;
    logic [MATCH_BITS-1:0]  match_cnt;

    logic [DATA_BITS-1:0]   aligned_c;
    logic [CNT_BITS-1:0]    manual_pos_c;

    // Window spans the previous and current word; earliest bit sits at the LSB.
    assign aligned_c    = DATA_BITS'({din, din_1} >> bitpos);
    assign manual_pos_c = (32'(manual_bitpos) >= DATA_BITS) ? POS_LAST : manual_bitpos;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            din_1 <= '0;
            dout  <= '0;
        end else begin
            din_1 <= din;
            dout  <= aligned_c;
        end
    end

    // Training FSM; manual override, restart and disable pre-empt normal transitions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            bitpos      <= '0;
            wait_cnt    <= '0;
            slip_cnt    <= '0;
            match_cnt   <= '0;
            lane_locked <= 1'b0;
            lane_err    <= 1'b0;
        end else if (manual_en) begin
            state       <= ST_IDLE;
            bitpos      <= manual_pos_c;
            lane_locked <= 1'b0;
            lane_err    <= 1'b0;
        end else if (restart) begin
            state       <= ST_SETTLE;
            wait_cnt    <= '0;
            slip_cnt    <= '0;
            match_cnt   <= '0;
            lane_locked <= 1'b0;
            lane_err    <= 1'b0;
        end else if (!align_en) begin
            state       <= ST_IDLE;
            lane_locked <= 1'b0;
            lane_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_SETTLE;
                    slip_cnt <= '0;
                    wait_cnt <= '0;
                end
                ST_SETTLE: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state     <= ST_CHECK;
                        match_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_BITS'(1);
                    end
                end
                ST_CHECK: begin
                    if (dout == TRAIN_PATTERN) begin
                        if (match_cnt == MATCH_LAST) begin
                            state       <= ST_LOCKED;
                            lane_locked <= 1'b1;
                        end else begin
                            match_cnt <= match_cnt + MATCH_BITS'(1);
                        end
                    end else if (slip_cnt != POS_LAST) begin
                        state <= ST_SLIP;
                    end else begin
                        state    <= ST_FAIL;
                        lane_err <= 1'b1;
                    end
                end
                ST_SLIP: begin
                    bitpos   <= (bitpos == POS_LAST) ? '0 : bitpos + CNT_BITS'(1);
                    slip_cnt <= slip_cnt + CNT_BITS'(1);
                    wait_cnt <= '0;
                    state    <= ST_SETTLE;
                end
                ST_LOCKED: begin
                    lane_locked <= 1'b1;
                end
                ST_FAIL: begin
                    lane_err    <= 1'b1;
                    lane_locked <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/bitslip_align.sv
// Multi-lane word aligner: independent per-lane bitslip trainers plus a global lock flag.
module bitslip_align
    import bitslip_pkg::*;
#(
    parameter int unsigned          NUM_LANES     = 4,
    parameter int unsigned          DATA_BITS     = 8,
    parameter int unsigned          CNT_BITS      = clogb2(DATA_BITS),
    parameter logic [DATA_BITS-1:0] TRAIN_PATTERN = DATA_BITS'(DEFAULT_TRAIN_PATTERN),
    parameter int unsigned          SETTLE_CYCLES = 3,
    parameter int unsigned          MATCH_COUNT   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           align_en,
    input  logic                           restart,
    input  logic                           manual_en,
    input  logic [NUM_LANES*CNT_BITS-1:0]  manual_bitpos,
    input  logic [NUM_LANES*DATA_BITS-1:0] din,
    output logic [NUM_LANES*DATA_BITS-1:0] dout,
    output logic [NUM_LANES*CNT_BITS-1:0]  bitpos,
    output logic [NUM_LANES-1:0]           lane_locked,
    output logic [NUM_LANES-1:0]           lane_err,
    output logic                           all_locked
);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        bitslip_lane #(
            .DATA_BITS     (DATA_BITS),
            .CNT_BITS      (CNT_BITS),
            .TRAIN_PATTERN (TRAIN_PATTERN),
            .SETTLE_CYCLES (SETTLE_CYCLES),
            .MATCH_COUNT   (MATCH_COUNT)
        ) u_lane (
            .clk           (clk),
            .rst_n         (rst_n),
            .align_en      (align_en),
            .restart       (restart),
            .manual_en     (manual_en),
            .manual_bitpos (manual_bitpos[g*CNT_BITS +: CNT_BITS]),
            .din           (din[g*DATA_BITS +: DATA_BITS]),
            .dout          (dout[g*DATA_BITS +: DATA_BITS]),
            .bitpos        (bitpos[g*CNT_BITS +: CNT_BITS]),
            .lane_locked   (lane_locked[g]),
            .lane_err      (lane_err[g])
        );
    end

    // Global lock lags the per-lane flags by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            all_locked <= 1'b0;
        end else begin
            all_locked <= &lane_locked;
        end
    end

endmodule

// File: tb/tb_bitslip_align.sv
// Self-checking bench for bitslip_align: random offsets/data against a serial-stream reference.
module tb_bitslip_align;

    localparam int unsigned NL = 4;
    localparam int unsigned DB = 8;
    localparam int unsigned CB = 3;
    localparam int unsigned SC = 3;
    localparam int unsigned MC = 16;
    localparam logic [7:0]  PAT = 8'h5C;
    localparam int          LOCK_BUDGET = 300;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              align_en;
    logic              restart;
    logic              manual_en;
    logic [NL*CB-1:0]  manual_bitpos;
    logic [NL*DB-1:0]  din;
    logic [NL*DB-1:0]  dout;
    logic [NL*CB-1:0]  bitpos;
    logic [NL-1:0]     lane_locked;
    logic [NL-1:0]     lane_err;
    logic              all_locked;

    int checks = 0;
    int errors = 0;
    int offs[NL];
    int model_pos[NL];

    always #5 clk = ~clk;

    bitslip_align #(
        .NUM_LANES(NL), .DATA_BITS(DB), .CNT_BITS(CB), .TRAIN_PATTERN(PAT),
        .SETTLE_CYCLES(SC), .MATCH_COUNT(MC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .align_en(align_en), .restart(restart),
        .manual_en(manual_en), .manual_bitpos(manual_bitpos), .din(din),
        .dout(dout), .bitpos(bitpos), .lane_locked(lane_locked),
        .lane_err(lane_err), .all_locked(all_locked)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word seen by the lane when the serial stream (repeating PAT) is cut 'off' bits late.
    function automatic logic [7:0] rot_word(input int off);
        logic [7:0] p;
        logic [7:0] r;
        p = PAT;
        for (int i = 0; i < 8; i++) r[i] = p[(i + off) % 8];
        return r;
    endfunction

    // Bit position that re-aligns a stream cut 'off' bits late.
    function automatic int exp_pos(input int off);
        return (DB - (off % DB)) % DB;
    endfunction

    function automatic logic [7:0] window_word(input logic [7:0] cur, input logic [7:0] prev,
                                               input int k);
        logic [15:0] w;
        w = {cur, prev};
        w = w >> k;
        return w[7:0];
    endfunction

    task automatic drive_offsets();
        for (int l = 0; l < NL; l++) din[l*DB +: DB] = rot_word(offs[l]);
    endtask

    // Run until every lane locks, checking all_locked lag, final position and latency bound.
    task automatic run_lock(input string tag);
        int cyc;
        logic prev_and;
        int lock_cyc[NL];
        int k, s, bound;
        for (int l = 0; l < NL; l++) lock_cyc[l] = -1;
        prev_and = &lane_locked;
        cyc = 0;
        while (!all_locked && cyc < LOCK_BUDGET) begin
            tick();
            cyc++;
            check($sformatf("%s/all_locked_lag@%0d", tag, cyc), 32'(all_locked), 32'(prev_and));
            prev_and = &lane_locked;
            for (int l = 0; l < NL; l++)
                if (lane_locked[l] && lock_cyc[l] < 0) lock_cyc[l] = cyc;
        end
        check($sformatf("%s/all_locked", tag), 32'(all_locked), 32'd1);
        for (int l = 0; l < NL; l++) begin
            k = exp_pos(offs[l]);
            s = (k - model_pos[l] + DB) % DB;
            bound = 1 + (s + 1) * (SC + 2) + MC + 2;
            check($sformatf("%s/bitpos%0d", tag, l), 32'(bitpos[l*CB +: CB]), 32'(k));
            check($sformatf("%s/dout%0d", tag, l), 32'(dout[l*DB +: DB]), 32'(PAT));
            check($sformatf("%s/err%0d", tag, l), 32'(lane_err[l]), 32'd0);
            check($sformatf("%s/latency%0d(%0d<=%0d)", tag, l, lock_cyc[l], bound),
                  32'(lock_cyc[l] > 0 && lock_cyc[l] <= bound), 32'd1);
            model_pos[l] = k;
        end
    endtask

    initial begin
        logic [7:0] prev_w[NL];
        logic [7:0] cur_w[NL];
        int mb[NL];
        int cyc;

        rst_n = 1'b0;
        align_en = 1'b0;
        restart = 1'b0;
        manual_en = 1'b0;
        manual_bitpos = '0;
        din = '0;
        for (int l = 0; l < NL; l++) model_pos[l] = 0;

        // Reset dominates random activity on every other input.
        for (int c = 0; c < 6; c++) begin
            din = {$urandom, $urandom};
            align_en = 1'($urandom);
            restart = 1'($urandom);
            manual_en = 1'($urandom);
            manual_bitpos = 12'($urandom);
            tick();
            check($sformatf("rst/dout@%0d", c), 32'(dout), 32'd0);
            check($sformatf("rst/bitpos@%0d", c), 32'(bitpos), 32'd0);
            check($sformatf("rst/locked@%0d", c), 32'(lane_locked), 32'd0);
            check($sformatf("rst/err@%0d", c), 32'(lane_err), 32'd0);
            check($sformatf("rst/all_locked@%0d", c), 32'(all_locked), 32'd0);
        end
        align_en = 1'b0;
        restart = 1'b0;
        manual_en = 1'b0;
        manual_bitpos = '0;
        din = '0;
        rst_n = 1'b1;
        tick();

        // Lane 0 offset 3, other lanes random.
        offs[0] = 3;
        for (int l = 1; l < NL; l++) offs[l] = int'($urandom_range(7));
        drive_offsets();
        align_en = 1'b1;
        run_lock("trainA");

        // Disabling clears flags but keeps positions.
        align_en = 1'b0;
        tick();
        for (int l = 0; l < NL; l++) begin
            check($sformatf("dis/locked%0d", l), 32'(lane_locked[l]), 32'd0);
            check($sformatf("dis/bitpos%0d", l), 32'(bitpos[l*CB +: CB]), 32'(model_pos[l]));
        end
        tick();
        check("dis/all_locked", 32'(all_locked), 32'd0);

        // Fixed offsets 0,2,5,7.
        offs[0] = 0; offs[1] = 2; offs[2] = 5; offs[3] = 7;
        drive_offsets();
        align_en = 1'b1;
        run_lock("trainB");

        // Restart with new offsets; lane 0 forced to a nonzero position for the wrap test.
        offs[0] = 1 + int'($urandom_range(6));
        for (int l = 1; l < NL; l++) offs[l] = int'($urandom_range(7));
        drive_offsets();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("rst_pulse/locked", 32'(lane_locked), 32'd0);
        check("rst_pulse/all_locked_lag", 32'(all_locked), 32'd1);
        tick();
        check("rst_pulse/all_locked", 32'(all_locked), 32'd0);
        run_lock("trainC");

        // Pattern absent: every lane walks all positions then flags an error.
        din = '0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        cyc = 0;
        while (lane_err != '1 && cyc < LOCK_BUDGET) begin
            tick();
            cyc++;
        end
        check("fail/timeout", 32'(cyc < LOCK_BUDGET), 32'd1);
        for (int l = 0; l < NL; l++) begin
            check($sformatf("fail/err%0d", l), 32'(lane_err[l]), 32'd1);
            check($sformatf("fail/locked%0d", l), 32'(lane_locked[l]), 32'd0);
            check($sformatf("fail/bitpos%0d", l), 32'(bitpos[l*CB +: CB]),
                  32'((model_pos[l] + DB - 1) % DB));
            model_pos[l] = (model_pos[l] + DB - 1) % DB;
        end
        for (int c = 0; c < 8; c++) tick();
        check("fail/err_hold", 32'(lane_err), 32'hF);
        check("fail/all_locked", 32'(all_locked), 32'd0);
        for (int l = 0; l < NL; l++)
            check($sformatf("fail/bitpos_hold%0d", l), 32'(bitpos[l*CB +: CB]), 32'(model_pos[l]));

        // Manual positions override training; output follows the two-word window.
        mb[0] = 5;
        for (int l = 1; l < NL; l++) mb[l] = int'($urandom_range(7));
        for (int l = 0; l < NL; l++) manual_bitpos[l*CB +: CB] = 3'(mb[l]);
        manual_en = 1'b1;
        tick();
        for (int l = 0; l < NL; l++) begin
            check($sformatf("man/bitpos%0d", l), 32'(bitpos[l*CB +: CB]), 32'(mb[l]));
            check($sformatf("man/locked%0d", l), 32'(lane_locked[l]), 32'd0);
            check($sformatf("man/err%0d", l), 32'(lane_err[l]), 32'd0);
            prev_w[l] = din[l*DB +: DB];
        end
        for (int c = 0; c < 20; c++) begin
            for (int l = 0; l < NL; l++) begin
                cur_w[l] = 8'($urandom);
                din[l*DB +: DB] = cur_w[l];
            end
            tick();
            for (int l = 0; l < NL; l++) begin
                check($sformatf("man/dout%0d@%0d", l, c), 32'(dout[l*DB +: DB]),
                      32'(window_word(cur_w[l], prev_w[l], mb[l])));
                prev_w[l] = cur_w[l];
            end
            check($sformatf("man/locked@%0d", c), 32'(lane_locked), 32'd0);
        end
        manual_en = 1'b0;
        align_en = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
